// File: rtl/pitch_renderer.sv
// pitch_renderer: VGA raster of pitch, goals, players and ball from per-frame shadow copies; optional `TIMER_BAR_EN time bar.
// Latency 2 pixel ticks (4 clk) from counters to pins; free-running display, no backpressure.
module pitch_renderer #(
  parameter int PLAYER_RADIUS = 16,
  parameter int BALL_RADIUS   = 6,
  parameter int GOAL_RADIUS   = 24,
  parameter int GOAL_X_OFFSET = 20,
  parameter int CLK_DIV       = 2,
  parameter int GOAL_Y        = 240,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  team1_hor_position,
  input  logic [9:0]  team1_ver_position,
  input  logic [9:0]  team2_hor_position,
  input  logic [9:0]  team2_ver_position,
  input  logic [18:0] ball_hor_position,
  input  logic [18:0] ball_ver_position,
  input  logic [7:0]  time_left,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SB   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SB   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GL_X   = 10'(GOAL_X_OFFSET);
  localparam logic [9:0] GR_X   = 10'(H_ACTIVE - GOAL_X_OFFSET);
  localparam logic [9:0] G_Y    = 10'(GOAL_Y);
  localparam logic [21:0] PR2   = 22'(PLAYER_RADIUS * PLAYER_RADIUS);
  localparam logic [21:0] BR2   = 22'(BALL_RADIUS * BALL_RADIUS);
  localparam logic [21:0] GR2   = 22'(GOAL_RADIUS * GOAL_RADIUS);
  localparam logic        DIV_OK = (CLK_DIV == 2);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  function automatic logic signed [10:0] f_diff(input logic [9:0] a, input logic [9:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [21:0] f_sq(input logic signed [10:0] d);
    logic signed [21:0] w_e;
    w_e = 22'(d);
    return w_e * w_e;
  endfunction

  logic        r_pix_tick;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        w_tick;
  logic        w_latch;
  pos_t        r_sh_ball, r_sh_t1, r_sh_t2;
  logic        r_frame_start;

  logic        r_s1_vis, r_s1_hs, r_s1_vs;
  logic signed [10:0] r_dx_ball, r_dy_ball, r_dx_t1, r_dy_t1, r_dx_t2, r_dy_t2;
  logic signed [10:0] r_dx_gl, r_dx_gr, r_dy_g;

  logic        w_in_ball, w_in_t1, w_in_t2, w_in_goal;
  logic [11:0] w_rgb;
  logic [11:0] r_rgb;
  logic        r_hsync, r_vsync;

  assign w_tick  = r_pix_tick;
  assign w_latch = w_tick && (r_h_cnt == 10'd0) && (r_v_cnt == V_VIS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_tick <= 1'b0;
      r_h_cnt    <= 10'd0;
      r_v_cnt    <= 10'd0;
    end else begin
      r_pix_tick <= ~r_pix_tick;
      if (w_tick) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= 10'd0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  // Positions are sampled only once per frame in vertical blank so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_ball     <= '0;
      r_sh_t1       <= '0;
      r_sh_t2       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_latch;
      if (w_latch) begin
        r_sh_ball <= '{x: ball_hor_position[9:0], y: ball_ver_position[9:0]};
        r_sh_t1   <= '{x: team1_hor_position, y: team1_ver_position};
        r_sh_t2   <= '{x: team2_hor_position, y: team2_ver_position};
      end
    end
  end

`ifdef TIMER_BAR_EN
  logic [7:0]  r_sh_time;
  logic [10:0] w_t7;
  logic [10:0] w_bar_w;
  logic        r_s1_bar;

  assign w_t7    = {r_sh_time, 3'b000} - {3'b000, r_sh_time};
  assign w_bar_w = {1'b0, w_t7[10:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_time <= 8'd0;
      r_s1_bar  <= 1'b0;
    end else begin
      if (w_latch)
        r_sh_time <= time_left;
      if (w_tick)
        r_s1_bar <= (r_v_cnt < 10'd8) && ({1'b0, r_h_cnt} < w_bar_w);
    end
  end

  logic w_unused;
  assign w_unused = ^{ball_hor_position[18:10], ball_ver_position[18:10], DIV_OK};
`else
  logic w_unused;
  assign w_unused = ^{ball_hor_position[18:10], ball_ver_position[18:10], time_left, DIV_OK};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vis  <= 1'b0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_dx_ball <= '0;
      r_dy_ball <= '0;
      r_dx_t1   <= '0;
      r_dy_t1   <= '0;
      r_dx_t2   <= '0;
      r_dy_t2   <= '0;
      r_dx_gl   <= '0;
      r_dx_gr   <= '0;
      r_dy_g    <= '0;
    end else if (w_tick) begin
      r_s1_vis  <= (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
      r_s1_hs   <= !((r_h_cnt >= H_SB) && (r_h_cnt < H_SE));
      r_s1_vs   <= !((r_v_cnt >= V_SB) && (r_v_cnt < V_SE));
      r_dx_ball <= f_diff(r_h_cnt, r_sh_ball.x);
      r_dy_ball <= f_diff(r_v_cnt, r_sh_ball.y);
      r_dx_t1   <= f_diff(r_h_cnt, r_sh_t1.x);
      r_dy_t1   <= f_diff(r_v_cnt, r_sh_t1.y);
      r_dx_t2   <= f_diff(r_h_cnt, r_sh_t2.x);
      r_dy_t2   <= f_diff(r_v_cnt, r_sh_t2.y);
      r_dx_gl   <= f_diff(r_h_cnt, GL_X);
      r_dx_gr   <= f_diff(r_h_cnt, GR_X);
      r_dy_g    <= f_diff(r_v_cnt, G_Y);
    end
  end

  always_comb begin
    w_in_ball = (f_sq(r_dx_ball) + f_sq(r_dy_ball)) <= BR2;
    w_in_t1   = (f_sq(r_dx_t1) + f_sq(r_dy_t1)) <= PR2;
    w_in_t2   = (f_sq(r_dx_t2) + f_sq(r_dy_t2)) <= PR2;
    w_in_goal = ((f_sq(r_dx_gl) + f_sq(r_dy_g)) <= GR2) ||
                ((f_sq(r_dx_gr) + f_sq(r_dy_g)) <= GR2);
    w_rgb = 12'h000;
    if (r_s1_vis) begin
      if (w_in_ball)
        w_rgb = 12'hFF0;
      else if (w_in_t1)
        w_rgb = 12'hF00;
      else if (w_in_t2)
        w_rgb = 12'h00F;
      else if (w_in_goal)
        w_rgb = 12'hFFF;
`ifdef TIMER_BAR_EN
      else if (r_s1_bar)
        w_rgb = 12'h0FF;
`endif
      else
        w_rgb = 12'h0A0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= 12'h000;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_rgb   <= w_rgb;
      r_hsync <= r_s1_hs;
      r_vsync <= r_s1_vs;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign frame_start = r_frame_start;

endmodule

// File: doc/pitch_renderer.md
Name: pitch_renderer

Overview:
- Display-side consumer of the game controller outputs: player positions, ball position and time left.
- Generates 640x480@60 VGA timing from the 50 MHz system clock.
- Latches object positions once per frame, during vertical blank, into shadow registers.
- Rasterises goals, players and ball as filled circles over a green pitch and drives 12-bit RGB plus syncs.

Parameters:
- PLAYER_RADIUS, 16, player circle radius in pixels.
- BALL_RADIUS, 6, ball circle radius in pixels.
- GOAL_RADIUS, 24, goal circle radius in pixels.
- GOAL_X_OFFSET, 20, goal centre x distance from the left and right edges; centre y is fixed at 240.
- CLK_DIV, 2, system clocks per pixel; only 2 is supported (25 MHz pixel tick).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- team1_hor_position  in  10  team 1 player centre x, pixels
- team1_ver_position  in  10  team 1 player centre y, pixels
- team2_hor_position  in  10  team 2 player centre x, pixels
- team2_ver_position  in  10  team 2 player centre y, pixels
- ball_hor_position  in  19  ball centre x; bits [9:0] are pixels, bits [18:10] are ignored
- ball_ver_position  in  19  ball centre y; bits [9:0] are pixels, bits [18:10] are ignored
- time_left  in  8  seconds remaining, 0..180
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- frame_start  out  1  one-clk pulse when the shadow registers latch

Behaviour:
- Reset (async on rst_n low):
  - pix_tick = 0, h_cnt = 0, v_cnt = 0.
  - hsync = 1, vsync = 1.
  - RGB = 0, frame_start = 0.
  - All shadow registers = 0.
- Pixel tick: pix_tick toggles every clk; counters and pipeline advance only on clks where pix_tick = 1.
- Horizontal counter: h_cnt counts 0..799 and wraps to 0.
  - Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter: v_cnt increments when h_cnt wraps; counts 0..524 and wraps to 0.
  - Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Pipeline: three stages, each advancing on a pixel tick.
  - S0: counters.
  - S1: registered dx/dy differences for every object.
  - S2: registered squared-distance compares, colour mux and RGB output.
  - hsync and vsync pass through a matching 2-tick delay, so RGB and syncs stay aligned.
  - Total latency from counter value to pins: 2 pixel ticks = 4 clk.
- Shadow latch: on the tick where h_cnt = 0 and v_cnt = 480 (S0), all position and time inputs are copied into the shadow registers and frame_start pulses high for 1 clk.
  - Input changes at any other time have no effect until the next latch, so there is no tearing.
- Circle test: dx = x − cx and dy = y − cy, each 11-bit signed. dx² + dy² is computed 22 bits wide, unsigned. A pixel is inside when that sum ≤ R².
  - No wrap-around: objects partly off-screen are clipped.
- Colour priority, highest first:
  - ball FF0
  - team1 player F00
  - team2 player 00F
  - goals FFF
  - pitch 0A0
- Outside the visible area, RGB = 000.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the next frame begins at h_cnt = 0, v_cnt = 0.
  - The shadows stay 0 until the first latch, so the first frame shows objects at (0,0), clipped.

Optional Feature:
- Macro: TIMER_BAR_EN.
- When defined:
  - Rows 0..7 show a horizontal bar, colour 0FF, spanning x < (shadow time_left × 7) >> 1.
  - At time_left = 180 the bar spans 630 pixels.
  - The bar has priority above the pitch only.
  - The multiply is implemented as shift-add; no multiplier is inferred.
- When undefined: rows 0..7 render like any other pitch rows, and time_left is unused.

Test Plan:
- Timing:
  - Stimulus: release rst_n, then measure syncs.
  - Response: first hsync falling edge 4 + 2×656 clk after the first tick. hsync low for 192 clk, period 1600 clk. vsync low for 2 lines, period 840000 clk.
- Ball render:
  - Stimulus: ball at (320,240), players at (100,100) and (540,100), latched.
  - Response: pixel (320,240) = FF0. Pixel (327,240) = 0A0. Pixel (20,240) = FFF. Pixel (100,100) = F00.
- Priority:
  - Stimulus: ball and team1 both at (200,300).
  - Response: (200,300) = FF0 and (212,300) = F00.
  - Stimulus: team1 and team2 both at (400,400).
  - Response: (400,400) = F00.
- Anti-tear:
  - Stimulus: move the ball from (320,240) to (500,240) while v_cnt = 100.
  - Response: rows 100..479 of that frame still show the ball at x = 320. The next frame shows it at 500. frame_start pulses once per frame.
- Reset mid-frame:
  - Stimulus: assert rst_n low at v_cnt = 250.
  - Response: hsync = vsync = 1 and RGB = 0 within the same clk edge. The counters restart at 0 after release.
- TIMER_BAR_EN:
  - Stimulus: time_left = 180, then 0.
  - Response at 180: row 3 is 0FF for x in 0..629 and 0A0 at x = 630.
  - Response at 0: no 0FF pixels.
